// File: rtl/l1c_core_responder.sv
// l1c_core_responder: direct-mapped write-through cache responder for the CPU core port; `define L1C_STATS_EN adds hit_cnt/miss_cnt
module l1c_core_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] core_addr,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [31:0] core_in,
    input  logic [2:0]  core_type,
    output logic [31:0] core_out,
    output logic        core_wait,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_wait
`ifdef L1C_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int SETS = 1 << INDEX_BITS;
    localparam int TW = 28 - INDEX_BITS;
    typedef enum logic [2:0] {IDLE, CHECK, FILL, WRITE, RESP} state_t;
    state_t state, next;
    logic [31:0] r_addr, r_in;
    logic r_write;
    logic [2:0] r_type;
    logic [1:0] cnt;
    logic [SETS-1:0] valid;
    logic [TW-1:0] tags [SETS];
    logic [31:0] data [SETS][4];
    logic [INDEX_BITS-1:0] idx;
    logic [TW-1:0] tag;
    logic hit, beat;
    logic [31:0] word, ext;
    logic [7:0] b;
    logic [15:0] h;
    logic [3:0] be;
    assign idx = r_addr[3+INDEX_BITS:4];
    assign tag = r_addr[31:4+INDEX_BITS];
    assign hit = valid[idx] && tags[idx] == tag;
    assign beat = mem_req && !mem_wait;
    assign word = data[idx][r_addr[3:2]];
    assign b = word[{r_addr[1:0], 3'b000} +: 8];
    assign h = word[{r_addr[1], 4'b0000} +: 16];
    assign ext = r_type[1:0] == 2'b00 ? {{24{~r_type[2] & b[7]}}, b}
               : r_type[1:0] == 2'b01 ? {{16{~r_type[2] & h[15]}}, h} : word;
    assign be = r_type[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0]
              : r_type[1:0] == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    always_comb begin
        next = state;
        core_wait = 1'b1;
        core_out = '0;
        mem_req = 1'b0;
        mem_write = 1'b0;
        mem_addr = '0;
        mem_type = 3'b010;
        mem_in = '0;
        case (state)
            IDLE: begin
                core_wait = core_req;
                next = core_req ? CHECK : IDLE;
            end
            CHECK: next = r_write ? WRITE : hit ? RESP : FILL;
            FILL: begin
                mem_req = 1'b1;
                mem_addr = {r_addr[31:4], cnt, 2'b00};
                next = beat && cnt == 2'd3 ? CHECK : FILL;
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_write = 1'b1;
                mem_addr = r_addr;
                mem_type = r_type;
                mem_in = r_in;
                next = beat ? RESP : WRITE;
            end
            RESP: begin
                core_wait = 1'b0;
                core_out = r_write ? '0 : ext;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            valid <= '0;
            cnt <= '0;
            r_addr <= '0;
            r_in <= '0;
            r_write <= 1'b0;
            r_type <= 3'b010;
        end else begin
            state <= next;
            if (state == IDLE && core_req) begin
                r_addr <= core_addr;
                r_in <= core_in;
                r_write <= core_write;
                r_type <= core_type;
            end
            // The line is invalidated while refilling so an abort never leaves stale words valid
            if (state == CHECK && !r_write && !hit) begin
                cnt <= '0;
                valid[idx] <= 1'b0;
            end
            if (state == FILL && beat) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) valid[idx] <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state == FILL && beat) begin
            data[idx][cnt] <= mem_out;
            if (cnt == 2'd3) tags[idx] <= tag;
        end
        if (state == WRITE && beat && hit)
            for (int k = 0; k < 4; k++)
                if (be[k]) data[idx][r_addr[3:2]][8*k +: 8] <= r_in[8*k +: 8];
    end
`ifdef L1C_STATS_EN
    logic refilled;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_cnt <= '0;
            miss_cnt <= '0;
            refilled <= 1'b0;
        end else begin
            if (state == CHECK && !r_write && hit && !refilled) hit_cnt <= hit_cnt + 32'd1;
            if (state == CHECK && !r_write && !hit) miss_cnt <= miss_cnt + 32'd1;
            refilled <= state == FILL;
        end
    end
`endif
endmodule

// File: tb/tb_l1c_core_responder.sv
// tb_l1c_core_responder: scoreboard bench with a wait-state memory model for l1c_core_responder
module tb_l1c_core_responder;
    localparam int WAIT = 2;
    logic clk = 0, rstn = 0;
    logic [31:0] core_addr = 0, core_in = 0, core_out, mem_addr, mem_in, mem_out;
    logic core_req = 0, core_write = 0, core_wait, mem_req, mem_write, mem_wait;
    logic [2:0] core_type = 3'b010, mem_type;
`ifdef L1C_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    int checks = 0, failures = 0, nbeats = 0, exp_hits = 0, exp_misses = 0;
    int wcnt = WAIT;
    logic [31:0] mem [4096];
    logic [31:0] wr_addr, wr_data;
    logic [2:0] wr_type;
    logic [31:0] expq[$], fillq[$];

    l1c_core_responder dut (
        .clk(clk), .rstn(rstn), .core_addr(core_addr), .core_req(core_req),
        .core_write(core_write), .core_in(core_in), .core_type(core_type),
        .core_out(core_out), .core_wait(core_wait), .mem_req(mem_req),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_type(mem_type),
        .mem_in(mem_in), .mem_out(mem_out), .mem_wait(mem_wait)
`ifdef L1C_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign mem_wait = wcnt != 0;
    assign mem_out = mem[mem_addr[13:2]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] t, input logic [1:0] a);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++)
            if (t[1:0] == 2'b00 ? k == a : t[1:0] == 2'b01 ? (k >> 1) == a[1] : 1'b1)
                r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rstn) wcnt <= WAIT;
        else if (mem_req && !mem_wait) begin
            wcnt <= WAIT;
            nbeats <= nbeats + 1;
            if (mem_write) begin
                wr_addr <= mem_addr;
                wr_type <= mem_type;
                wr_data <= mem_in;
                mem[mem_addr[13:2]] <= merge(mem[mem_addr[13:2]], mem_in, mem_type, mem_addr[1:0]);
            end else fillq.push_back(mem_addr);
        end else if (mem_req && wcnt != 0) wcnt <= wcnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 0;
        core_req = 0;
        repeat (2) @(posedge clk);
        #1;
        fillq.delete();
        expq.delete();
        exp_hits = 0;
        exp_misses = 0;
        check("rst_core_wait", {31'b0, core_wait}, 0);
        check("rst_mem_req", {31'b0, mem_req}, 0);
        check("rst_mem_write", {31'b0, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_in", mem_in, 0);
        check("rst_mem_type", {29'b0, mem_type}, 32'd2);
        check("rst_core_out", core_out, 0);
`ifdef L1C_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        @(negedge clk) rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] d, input logic [31:0] exp, input logic exp_hit);
        int n = 0, b0 = nbeats;
        logic done = 0;
        logic [31:0] e;
        if (!w) expq.push_back(exp);
        core_addr = a; core_write = w; core_type = t; core_in = d; core_req = 1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!core_wait) done = 1;
        end
        check("resp_seen", {31'b0, done}, 1);
        if (!w) begin
            e = expq.pop_front();
            check("load_data", core_out, e);
            check("load_beats", nbeats - b0, exp_hit ? 0 : 4);
            check("load_latency", n, exp_hit ? 2 : 3 + 4 * (WAIT + 1));
            if (!exp_hit)
                for (int k = 0; k < 4; k++)
                    check("fill_addr", fillq.size() > 0 ? fillq.pop_front() : 32'hdead_beef,
                          {a[31:4], 4'b0} + 32'(4 * k));
            if (exp_hit) exp_hits++;
            else exp_misses++;
        end else begin
            check("store_beats", nbeats - b0, 1);
            check("store_latency", n, 3 + WAIT);
            check("store_addr", wr_addr, a);
            check("store_type", {29'b0, wr_type}, {29'b0, t});
            check("store_data", wr_data, d);
        end
`ifdef L1C_STATS_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
`endif
        core_req = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, b0;
        for (int i = 0; i < 4096; i++) mem[i] = 0;
        mem['h400] = 32'h11; mem['h401] = 32'h22; mem['h402] = 32'h33; mem['h403] = 32'h44;
        mem['h440] = 32'h55aa_55aa;
        do_reset();
        access(0, 32'h1004, 3'b010, 0, 32'h22, 0);
        access(0, 32'h1004, 3'b010, 0, 32'h22, 1);
        access(0, 32'h100c, 3'b010, 0, 32'h44, 1);
        mem['h400] = 32'h8081_f27f;
        do_reset();
        access(0, 32'h1000, 3'b000, 0, 32'h0000_007f, 0);
        access(0, 32'h1001, 3'b000, 0, 32'hffff_fff2, 1);
        access(0, 32'h1003, 3'b100, 0, 32'h0000_0080, 1);
        access(0, 32'h1002, 3'b001, 0, 32'hffff_8081, 1);
        access(0, 32'h1002, 3'b101, 0, 32'h0000_8081, 1);
        access(0, 32'h1000, 3'b001, 0, 32'hffff_f27f, 1);
        access(0, 32'h1000, 3'b111, 0, 32'h8081_f27f, 1);
        access(1, 32'h1001, 3'b000, 32'h0000_ab00, 0, 0);
        access(0, 32'h1000, 3'b010, 0, 32'h8081_ab7f, 1);
        access(1, 32'h1002, 3'b001, 32'h1234_0000, 0, 0);
        access(0, 32'h1000, 3'b010, 0, 32'h1234_ab7f, 1);
        access(1, 32'h2000, 3'b010, 32'hcafe_f00d, 0, 0);
        access(0, 32'h2000, 3'b010, 0, 32'hcafe_f00d, 0);
        access(0, 32'h1100, 3'b010, 0, 32'h55aa_55aa, 0);
        access(0, 32'h1000, 3'b010, 0, 32'h1234_ab7f, 0);
        access(0, 32'h1000, 3'b010, 0, 32'h1234_ab7f, 1);
        do_reset();
        b0 = nbeats;
        n = 0;
        core_addr = 32'h1000; core_write = 0; core_type = 3'b010; core_req = 1;
        while (nbeats < b0 + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_beat2", nbeats - b0, 2);
        check("abort_in_fill", {31'b0, mem_req}, 1);
        rstn = 0;
        #1;
        check("abort_mem_req", {31'b0, mem_req}, 0);
        core_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1;
        fillq.delete();
        exp_hits = 0;
        exp_misses = 0;
        @(posedge clk);
        #1;
        access(0, 32'h1000, 3'b010, 0, 32'h1234_ab7f, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
